div32_seq: RTL and testbench

Iterative 32-bit integer divider for the CPU datapath's multi-cycle arithmetic path, the subtractive counterpart to the combinational 32-bit adder. It accepts a dividend/divisor pair on a start pulse and runs one restoring shift-subtract step per clock. It returns quotient and remainder with a one-cycle done pulse. Signed (two's complement) and unsigned modes are selected per operation.

---
 rtl/div_pkg.sv | 13 +
 rtl/div_step.sv | 22 ++
 rtl/div32_seq.sv | 96 +++++++++
 tb/tb_div32_seq.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the iterative 32-bit divider.
package div_pkg;
  localparam int WIDTH      = 32;
  localparam int ITER_COUNT = 32;

  localparam logic [WIDTH-1:0] DBZ_QUOT = '1;

  typedef logic [1:0] div_state_t;
  localparam div_state_t ST_IDLE = 2'd0;
  localparam div_state_t ST_RUN  = 2'd1;
  localparam div_state_t ST_FIX  = 2'd2;
  localparam div_state_t ST_DONE = 2'd3;
endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration; carry-out of the (W+1)-bit subtract means no borrow.
module div_step
  import div_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] rem_in,
  input  logic         in_bit,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);
  logic [W:0]   shifted;
  logic [W+1:0] sum;

  assign shifted = {rem_in, in_bit};
  // shifted + ~{0,divisor} + 1, widened one bit so the carry-out is visible
  assign sum     = {1'b0, shifted} + {1'b0, ~{1'b0, divisor}} + (W+2)'(1);
  assign q_bit   = sum[W+1];
  // on success the difference is below divisor, so the low W bits hold it exactly
  assign rem_out = q_bit ? sum[W-1:0] : shifted[W-1:0];
endmodule

// File: rtl/div32_seq.sv
// Iterative signed/unsigned divider: magnitude restoring division, one bit per clock,
// followed by a sign fix-up cycle and a one-cycle done pulse.
module div32_seq
  import div_pkg::*;
#(
  parameter int WIDTH = div_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  div_state_t       state;
  logic [5:0]       cnt;
  logic [WIDTH-1:0] div_r, rem_r, quo_r;
  logic             neg_q, neg_r, sgn_r;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign a_abs = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign b_abs = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  div_step #(.W(WIDTH)) u_step (
    .rem_in  (rem_r),
    .in_bit  (quo_r[WIDTH-1]),
    .divisor (div_r),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      div_r       <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      sgn_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          div_by_zero <= 1'b0;
          if (divisor == '0) begin
            quotient    <= DBZ_QUOT[WIDTH-1:0];
            remainder   <= dividend;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            state       <= ST_DONE;
          end else begin
            // quotient register doubles as the dividend shift source
            quo_r <= a_abs;
            div_r <= b_abs;
            rem_r <= '0;
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
            sgn_r <= is_signed;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          rem_r <= step_rem;
          quo_r <= {quo_r[WIDTH-2:0], step_q};
          cnt   <= cnt + 6'd1;
          if (cnt == 6'(ITER_COUNT - 1)) state <= ST_FIX;
        end
        ST_FIX: begin
          quotient  <= (sgn_r && neg_q) ? -quo_r : quo_r;
          remainder <= (sgn_r && neg_r) ? -rem_r : rem_r;
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: directed vector table, corner sequences, random ops vs. arithmetic model.
module tb_div32_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend, divisor;
  logic [31:0] quotient, remainder;
  logic        busy, done, div_by_zero;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div32_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .quotient(quotient),
    .remainder(remainder), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic        sgn;
    logic [31:0] a, b, q, r;
    logic        dbz;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic in 64-bit, which truncates toward zero
  // and keeps the remainder sign with the dividend.
  function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic dbz);
    longint sa, sb;
    dbz = (b == 0);
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Called at a negedge with the DUT idle. Returns at the negedge where done is seen.
  // inj > 0 pulses a second start (9/3) so it is sampled at edge E<inj>.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic exp_dbz, input int inj, output int lat, output int busy_err);
    start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dividend = $urandom; divisor = $urandom;
    lat = 0;
    busy_err = 0;
    while (!done && lat < 100) begin
      if (busy !== 1'b1 || exp_dbz) busy_err++;
      start = (inj > 0 && lat + 1 == inj);
      if (start) begin is_signed = 1'b0; dividend = 32'd9; divisor = 32'd3; end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    if (busy !== 1'b0) busy_err++;
  endtask

  task automatic do_check(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input int inj);
    logic [31:0] eq, er;
    logic        ed;
    int          lat, berr;
    ref_div(sgn, a, b, eq, er, ed);
    run_op(sgn, a, b, ed, inj, lat, berr);
    if (!done) begin
      failures++; checks++;
      $display("FAIL %s timeout: done never seen within 100 cycles", tag);
    end else begin
      check({tag, " quot"}, quotient, eq);
      check({tag, " rem"}, remainder, er);
      check({tag, " dbz"}, {31'd0, div_by_zero}, {31'd0, ed});
      check({tag, " latency"}, lat, ed ? 0 : 33);
      check({tag, " busy"}, berr, 0);
    end
    @(negedge clk);
    check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, " held"}, quotient ^ remainder, eq ^ er);
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2,        1'b0};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,       1'b0};
    vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,       1'b0};
    vecs[4] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0};
    vecs[5] = '{1'b0, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'd5,        1'b1};
    vecs[6] = '{1'b1, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'd5,        1'b1};
    vecs[7] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,        32'd0,        1'b0};
    vecs[8] = '{1'b1, 32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0};
    vecs[9] = '{1'b0, 32'hFFFF_FFFE,  32'h8000_0001, 32'd1,        32'h7FFF_FFFD, 1'b0};

    reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("reset quot", quotient, 32'd0);
    check("reset rem", remainder, 32'd0);
    check("reset flags", {29'd0, busy, done, div_by_zero}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      logic [31:0] mq, mr;
      logic        md;
      int          lat, berr;
      ref_div(vecs[i].sgn, vecs[i].a, vecs[i].b, mq, mr, md);
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].dbz, 0, lat, berr);
      check($sformatf("vec%0d quot", i), quotient, vecs[i].q);
      check($sformatf("vec%0d rem", i), remainder, vecs[i].r);
      check($sformatf("vec%0d dbz", i), {31'd0, div_by_zero}, {31'd0, vecs[i].dbz});
      check($sformatf("vec%0d latency", i), lat, vecs[i].dbz ? 0 : 33);
      check($sformatf("vec%0d busy", i), berr, 0);
      check($sformatf("vec%0d model", i), mq ^ mr, vecs[i].q ^ vecs[i].r);
      @(negedge clk);
      check($sformatf("vec%0d done_pulse", i), {31'd0, done}, 32'd0);
      check($sformatf("vec%0d dbz_held", i), {31'd0, div_by_zero}, {31'd0, vecs[i].dbz});
    end

    // start pulsed mid-operation must be dropped; a start right after DONE is taken
    do_check("ignore_start", 1'b0, 32'hFFFF_FFFF, 32'd1, 10);
    do_check("after_ignore", 1'b0, 32'd9, 32'd3, 0);

    // asynchronous reset in the middle of an operation
    start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (12) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset quot", quotient, 32'd0);
    check("midreset rem", remainder, 32'd0);
    check("midreset flags", {29'd0, busy, done, div_by_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_check("post_reset", 1'b0, 32'd100, 32'd7, 0);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a, b;
      logic        s;
      s = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      do_check($sformatf("rand%0d", n), s, a, b, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
